// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: ALUOp/ALUdone handshake and operand/result bus between controller and execute unit
interface alu_multicycle_if #(parameter int WIDTH = 16);
  logic start;
  logic [5:0] ALUOp;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic carry;
  logic zero;
  logic div_by_zero;
  logic op_err;
  logic busy;
  logic ALUdone;
  modport master (
    output start, ALUOp, a, b,
    input result, result_hi, carry, zero, div_by_zero, op_err, busy, ALUdone
  );
  modport slave (
    input start, ALUOp, a, b,
    output result, result_hi, carry, zero, div_by_zero, op_err, busy, ALUdone
  );
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: 1-cycle ADD/SUB, iterative shift-add MUL and restoring DIV; `define ALU_SIGNED_EN for two's-complement MUL/DIV
module alu_multicycle #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic reset,
  alu_multicycle_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [WIDTH-1:0] mcand, mplier, rem, quo, dvsr, rem_nxt, quo_nxt;
  logic [WIDTH-1:0] a_mag, b_mag, fast_res, fin_lo, fin_hi;
  logic [WIDTH:0] add_s, sub_s, shifted, trial;
  logic slow;
`ifdef ALU_SIGNED_EN
  logic neg_q, neg_r;
  always_ff @(posedge clk)
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      neg_r <= bus.a[WIDTH-1];
    end
`endif
  always_comb begin
    add_s = {1'b0, bus.a} + {1'b0, bus.b};
    sub_s = {1'b0, bus.a} - {1'b0, bus.b};
    fast_res = bus.ALUOp == 6'd0 ? add_s[WIDTH-1:0] :
               bus.ALUOp == 6'd1 ? sub_s[WIDTH-1:0] :
               bus.ALUOp == 6'd3 ? '1 : bus.a;
    slow = bus.ALUOp == 6'd2 || (bus.ALUOp == 6'd3 && bus.b != '0);
    // MSB-first shift-add keeps the whole accumulator in the shifted term
    acc_nxt = (acc << 1) + {{WIDTH{1'b0}}, {WIDTH{mplier[WIDTH-1]}} & mcand};
    shifted = {rem, quo[WIDTH-1]};
    trial = shifted - {1'b0, dvsr};
    rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
`ifdef ALU_SIGNED_EN
    a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
    b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;
    prod = neg_q ? -acc_nxt : acc_nxt;
    fin_lo = state == MUL ? prod[WIDTH-1:0] : neg_q ? -quo_nxt : quo_nxt;
    fin_hi = state == MUL ? prod[2*WIDTH-1:WIDTH] : neg_r ? -rem_nxt : rem_nxt;
`else
    a_mag = bus.a;
    b_mag = bus.b;
    prod = acc_nxt;
    fin_lo = state == MUL ? prod[WIDTH-1:0] : quo_nxt;
    fin_hi = state == MUL ? prod[2*WIDTH-1:WIDTH] : rem_nxt;
`endif
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      rem <= '0;
      quo <= '0;
      dvsr <= '0;
      bus.result <= '0;
      bus.result_hi <= '0;
      bus.carry <= 1'b0;
      bus.zero <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.op_err <= 1'b0;
      bus.busy <= 1'b0;
      bus.ALUdone <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (bus.start && slow) begin
            cnt <= CNT_W'(WIDTH);
            bus.busy <= 1'b1;
            if (bus.ALUOp == 6'd2) begin
              acc <= '0;
              mcand <= a_mag;
              mplier <= b_mag;
              state <= MUL;
            end else begin
              rem <= '0;
              quo <= a_mag;
              dvsr <= b_mag;
              state <= DIV;
            end
          end else if (bus.start) begin
            bus.result <= fast_res;
            bus.result_hi <= bus.ALUOp == 6'd3 ? bus.a : '0;
            bus.carry <= bus.ALUOp == 6'd0 ? add_s[WIDTH] : bus.ALUOp == 6'd1 ? sub_s[WIDTH] : 1'b0;
            bus.zero <= fast_res == '0;
            bus.div_by_zero <= bus.ALUOp == 6'd3;
            bus.op_err <= bus.ALUOp > 6'd3;
            bus.ALUdone <= 1'b1;
            state <= DONE;
          end
        MUL, DIV: begin
          if (state == MUL) begin
            acc <= acc_nxt;
            mplier <= mplier << 1;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
          end
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            bus.result <= fin_lo;
            bus.result_hi <= fin_hi;
            bus.carry <= 1'b0;
            bus.zero <= fin_lo == '0;
            bus.div_by_zero <= 1'b0;
            bus.op_err <= 1'b0;
            bus.busy <= 1'b0;
            bus.ALUdone <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          bus.ALUdone <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: randomized and directed checks of alu_multicycle against an arithmetic reference model
module tb_alu_multicycle;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  alu_multicycle_if #(.WIDTH(16)) bus ();
  alu_multicycle #(.WIDTH(16), .CNT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // packed layout: {result, result_hi, carry, zero, div_by_zero, op_err, latency[8], busy_cycles[8], done_after}
  function automatic logic [52:0] model(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r, h;
    logic c, dbz, err;
    int lat, bsy, sa, sb, q, m;
    logic [31:0] p;
    r = '0; h = '0; c = 1'b0; dbz = 1'b0; err = 1'b0; lat = 1; bsy = 0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op == 6'd0) {c, r} = {1'b0, a} + {1'b0, b};
    else if (op == 6'd1) begin
      r = a - b;
      c = a < b;
    end else if (op == 6'd2) begin
      lat = 17; bsy = 16;
`ifdef ALU_SIGNED_EN
      p = 32'(sa * sb);
`else
      p = 32'(a) * 32'(b);
`endif
      r = p[15:0]; h = p[31:16];
    end else if (op == 6'd3 && b == 16'h0) begin
      r = 16'hFFFF; h = a; dbz = 1'b1;
    end else if (op == 6'd3) begin
      lat = 17; bsy = 16;
`ifdef ALU_SIGNED_EN
      q = sa / sb; m = sa % sb;
`else
      q = int'(a) / int'(b); m = int'(a) % int'(b);
`endif
      r = 16'(q); h = 16'(m);
    end else begin
      r = a; err = 1'b1;
    end
    return {r, h, c, r == 16'h0, dbz, err, 8'(lat), 8'(bsy), 1'b0};
  endfunction
  task automatic do_op(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b, output logic [52:0] got);
    int lat, bn;
    logic [35:0] outs;
    @(negedge clk);
    bus.start = 1'b1; bus.ALUOp = op; bus.a = a; bus.b = b;
    lat = 0; bn = 0;
    do begin
      @(negedge clk);
      if (lat == 0) begin
        bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom); bus.ALUOp = 6'($urandom_range(0, 3));
      end
      lat++;
      if (bus.busy) bn++;
    end while (bus.ALUdone !== 1'b1 && lat < 40);
    outs = {bus.result, bus.result_hi, bus.carry, bus.zero, bus.div_by_zero, bus.op_err};
    @(negedge clk);
    got = {outs, 8'(lat), 8'(bn), bus.ALUdone};
  endtask
  task automatic test_reset;
    bus.start = 1'b0; bus.ALUOp = '0; bus.a = '0; bus.b = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.result, bus.result_hi, bus.carry, bus.zero, bus.div_by_zero, bus.op_err, bus.busy, bus.ALUdone} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h required=0", {bus.result, bus.result_hi, bus.carry, bus.zero, bus.div_by_zero, bus.op_err, bus.busy, bus.ALUdone});
    end
    reset = 1'b0;
  endtask
  task automatic test_add_sub;
    logic [52:0] got, exp;
    logic [5:0] op;
    logic [15:0] a, b;
    for (int i = 0; i < 14; i++) begin
      op = i < 3 ? (i == 0 ? 6'd0 : 6'd1) : 6'($urandom_range(0, 1));
      a = i == 0 ? 16'hFFFF : i == 1 ? 16'd5 : i == 2 ? 16'd7 : 16'($urandom);
      b = i == 0 ? 16'h0002 : i == 1 ? 16'd7 : i == 2 ? 16'd7 : (i == 3 ? a : 16'($urandom));
      do_op(op, a, b, got);
      exp = model(op, a, b);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL add_sub op=%0d a=%h b=%h got=%h required=%h", op, a, b, got, exp);
      end
    end
  endtask
  task automatic test_mul;
    logic [52:0] got, exp;
    logic [15:0] a, b;
    for (int i = 0; i < 10; i++) begin
      a = i == 0 ? 16'h1234 : i == 1 ? 16'hFFFA : i == 2 ? 16'hFFFF : i == 3 ? 16'h8000 : 16'($urandom);
      b = i == 0 ? 16'h0100 : i == 1 ? 16'd3 : i == 2 ? 16'hFFFF : i == 3 ? 16'h0 : 16'($urandom);
      do_op(6'd2, a, b, got);
      exp = model(6'd2, a, b);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mul a=%h b=%h got=%h required=%h", a, b, got, exp);
      end
    end
  endtask
  task automatic test_div;
    logic [52:0] got, exp;
    logic [15:0] a, b;
    for (int i = 0; i < 12; i++) begin
      a = i == 0 ? 16'd100 : i == 1 ? 16'd9 : i == 2 ? 16'h8000 : i == 3 ? 16'hFFFF : i == 4 ? 16'd5 : 16'($urandom);
      b = i == 0 ? 16'd7 : i == 1 ? 16'd0 : i == 2 ? 16'hFFFF : i == 3 ? 16'd1 : i == 4 ? 16'd9 :
          (i == 5 ? 16'd0 : 16'($urandom_range(1, 400)));
      do_op(6'd3, a, b, got);
      exp = model(6'd3, a, b);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL div a=%h b=%h got=%h required=%h", a, b, got, exp);
      end
    end
  endtask
  task automatic test_random;
    logic [52:0] got, exp;
    logic [5:0] op;
    logic [15:0] a, b;
    for (int i = 0; i < 20; i++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
      a = 16'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      do_op(op, a, b, got);
      exp = model(op, a, b);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random op=%0d a=%h b=%h got=%h required=%h", op, a, b, got, exp);
      end
    end
  endtask
  task automatic test_reset_mid_op;
    logic [52:0] got, exp;
    int pulses;
    @(negedge clk);
    bus.start = 1'b1; bus.ALUOp = 6'd2; bus.a = 16'h1234; bus.b = 16'h5678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_op_busy got=%b required=1", bus.busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus.result, bus.result_hi, bus.carry, bus.zero, bus.div_by_zero, bus.op_err, bus.busy, bus.ALUdone} !== '0) begin
      errors++;
      $display("FAIL abort_clears got=%h required=0", {bus.result, bus.result_hi, bus.carry, bus.zero, bus.div_by_zero, bus.op_err, bus.busy, bus.ALUdone});
    end
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ALUdone === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL abort_no_done got=%0d required=0", pulses);
    end
    do_op(6'd0, 16'd3, 16'd4, got);
    exp = model(6'd0, 16'd3, 16'd4);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL add_after_abort got=%h required=%h", got, exp);
    end
  endtask
  task automatic test_back_to_back;
    logic [52:0] got, exp;
    int pulses;
    @(negedge clk);
    bus.start = 1'b1; bus.ALUOp = 6'd0; bus.a = 16'd1; bus.b = 16'd1;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.ALUdone !== 1'((i % 2) == 1)) begin
        errors++;
        $display("FAIL b2b_done cycle=%0d got=%b required=%b", i, bus.ALUdone, 1'((i % 2) == 1));
      end
      if (bus.ALUdone === 1'b1) pulses++;
      if (i == 10) bus.start = 1'b0;
    end
    checks++;
    if (pulses != 5 || bus.result !== 16'd2) begin
      errors++;
      $display("FAIL b2b_count pulses=%0d result=%h required 5 and 0002", pulses, bus.result);
    end
    do_op(6'd6, 16'hBEEF, 16'h1111, got);
    exp = model(6'd6, 16'hBEEF, 16'h1111);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL illegal_op got=%h required=%h", got, exp);
    end
  endtask
  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
